// File: rtl/pwm_comparador.sv
// pwm_comparador: samples a ripple counter's count on the rising edge and
// detects period wrap. Compares the sampled count against a double-buffered
// duty value to give a registered, glitch-free PWM output and a one-cycle
// wrap tick.
module pwm_comparador #(
    parameter int Size = 8
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [Size-1:0] count,
    input  logic [Size-1:0] duty,
    input  logic            duty_ld,
    output logic            busy,
    output logic [Size-1:0] cnt_q,
    output logic            pwm,
    output logic            wrap
);

    localparam logic [Size-1:0] CntMax = '1;

    logic [Size-1:0] cnt_d;
    logic [Size-1:0] cnt_prev_q,  cnt_prev_d;
    logic [Size-1:0] duty_act_q,  duty_act_d;
    logic [Size-1:0] duty_pend_q, duty_pend_d;
    logic            busy_q,      busy_d;
    logic            pwm_q,       pwm_d;
    logic            wrap_q,      wrap_d;

    logic            wrap_c;
    logic [Size-1:0] d_eff;

    // Wrap detect, duty handshake and PWM compare for the next edge.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        cnt_d       = count;
        cnt_prev_d  = cnt_q;
        duty_act_d  = duty_act_q;
        duty_pend_d = duty_pend_q;
        busy_d      = busy_q;

        // A rollover is seen only as max followed directly by zero, so a
        // stalled counter or a clear from a non-max value gives no tick.
        wrap_c = (cnt_q == '0) && (cnt_prev_q == CntMax);

        if (busy_q) begin
            // A load while busy is ignored; the pending value is applied
            // at the wrap, which also frees the buffer.
            if (wrap_c) begin
                duty_act_d = duty_pend_q;
                busy_d     = 1'b0;
            end
        end else if (duty_ld) begin
            // Captured even on a wrap edge; it then waits for the next wrap.
            duty_pend_d = duty;
            busy_d      = 1'b1;
        end

        // The first cycle of a new period already uses the new duty, so a
        // period never mixes two duty values.
        d_eff  = (wrap_c && busy_q) ? duty_pend_q : duty_act_q;
        pwm_d  = (cnt_q < d_eff);
        wrap_d = wrap_c;
    end

    // State registers, cleared asynchronously by clr.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q       <= '0;
            cnt_prev_q  <= '0;
            duty_act_q  <= '0;
            duty_pend_q <= '0;
            busy_q      <= 1'b0;
            pwm_q       <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            cnt_q       <= cnt_d;
            cnt_prev_q  <= cnt_prev_d;
            duty_act_q  <= duty_act_d;
            duty_pend_q <= duty_pend_d;
            busy_q      <= busy_d;
            pwm_q       <= pwm_d;
            wrap_q      <= wrap_d;
        end
    end

    assign busy = busy_q;
    assign pwm  = pwm_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_pwm_comparador.sv
// Directed bench for pwm_comparador with Size=4. The bench plays the ripple
// counter itself: count advances on the clk falling edge while cnt_en is set.
// Outputs are sampled 1 time unit after each rising edge.
module tb_pwm_comparador;

    localparam int Size = 4;

    logic            clk = 1'b0;
    logic            clr;
    logic [Size-1:0] count;
    logic [Size-1:0] duty;
    logic            duty_ld;
    logic            busy;
    logic [Size-1:0] cnt_q;
    logic            pwm;
    logic            wrap;

    logic            cnt_en;
    int              n_checks = 0;
    int              n_pass   = 0;

    pwm_comparador #(.Size(Size)) dut (
        .clk     (clk),
        .clr     (clr),
        .count   (count),
        .duty    (duty),
        .duty_ld (duty_ld),
        .busy    (busy),
        .cnt_q   (cnt_q),
        .pwm     (pwm),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One clock: counter steps on the falling edge, DUT samples on the
    // rising edge, outputs are read just after it.
    task automatic tick();
        @(negedge clk);
        if (cnt_en) count = count + 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input logic [Size-1:0] v);
        for (int i = 0; i < 40; i++) begin
            if (count == v) return;
            tick();
        end
        $display("FAIL run_to: count %0d never reached %0d", count, v);
        $fatal(1, "counter stuck");
    endtask

    task automatic load(input logic [Size-1:0] d);
        duty    = d;
        duty_ld = 1'b1;
        tick();
        duty_ld = 1'b0;
    endtask

    // Called with count==0: the 16 samples cover counts 1..15,0, i.e. one
    // full period aligned to the pwm/wrap latency.
    task automatic measure(output int highs, output int wraps,
                           output int low_at, output int wrap_at);
        highs = 0; wraps = 0; low_at = -1; wrap_at = -1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (pwm)  highs++;
            else      low_at = int'(count);
            if (wrap) begin
                wraps++;
                wrap_at = int'(count);
            end
        end
    endtask

    int highs, wraps, low_at, wrap_at, changes, total_h, total_w;
    logic pwm_last;

    initial begin
        clr = 1'b1; count = '0; duty = '0; duty_ld = 1'b0; cnt_en = 1'b0;
        tick();
        tick();
        check("rst_cnt_q", 32'(cnt_q), 0);
        check("rst_pwm",   32'(pwm),   0);
        check("rst_wrap",  32'(wrap),  0);
        check("rst_busy",  32'(busy),  0);
        clr = 1'b0;
        cnt_en = 1'b1;

        // Nominal: duty 4
        run_to(4'd5);
        check("pre_wrap_pwm_dead", 32'(wrap), 0);
        load(4'd4);
        check("nom_busy_set", 32'(busy), 1);
        check("nom_pwm_before_apply", 32'(pwm), 0);
        run_to(4'd0);
        check("nom_busy_at_wrap_c", 32'(busy), 1);
        check("nom_no_wrap_yet", 32'(wrap), 0);
        tick();
        check("nom_wrap_pulse", 32'(wrap), 1);
        check("nom_busy_clear", 32'(busy), 0);
        check("nom_pwm_first", 32'(pwm), 1);
        run_to(4'd4);
        check("nom_pwm_last_high", 32'(pwm), 1);
        tick();
        check("nom_pwm_first_low", 32'(pwm), 0);
        run_to(4'd0);
        measure(highs, wraps, low_at, wrap_at);
        check("nom_highs", 32'(highs), 4);
        check("nom_wraps", 32'(wraps), 1);
        check("nom_wrap_at", 32'(wrap_at), 1);

        // Mid-period clear, with a pending load that must be discarded
        run_to(4'd6);
        load(4'd9);
        check("clr_busy_before", 32'(busy), 1);
        clr = 1'b1;
        #2;
        check("clr_async_cnt_q", 32'(cnt_q), 0);
        check("clr_async_pwm",   32'(pwm),   0);
        check("clr_async_wrap",  32'(wrap),  0);
        check("clr_async_busy",  32'(busy),  0);
        clr = 1'b0;
        run_to(4'd0);
        measure(highs, wraps, low_at, wrap_at);
        check("clr_pwm_stays_0", 32'(highs), 0);
        check("clr_wraps", 32'(wraps), 1);
        check("clr_pending_gone", 32'(busy), 0);

        // Extremes: duty 0 over three periods, then duty 15
        tick();
        load(4'd0);
        run_to(4'd0);
        total_h = 0; total_w = 0;
        for (int p = 0; p < 3; p++) begin
            measure(highs, wraps, low_at, wrap_at);
            total_h += highs;
            total_w += wraps;
        end
        check("duty0_highs", 32'(total_h), 0);
        check("duty0_wraps", 32'(total_w), 3);
        tick();
        load(4'd15);
        run_to(4'd0);
        measure(highs, wraps, low_at, wrap_at);
        check("duty15_highs", 32'(highs), 15);
        check("duty15_low_at", 32'(low_at), 0);

        // Ignored load: 3 is kept, 9 is dropped
        tick();
        load(4'd3);
        run_to(4'd5);
        load(4'd9);
        check("ign_busy_held", 32'(busy), 1);
        run_to(4'd0);
        check("ign_busy_at_wrap_c", 32'(busy), 1);
        tick();
        check("ign_wrap", 32'(wrap), 1);
        check("ign_busy_fall", 32'(busy), 0);
        run_to(4'd0);
        measure(highs, wraps, low_at, wrap_at);
        check("ign_highs", 32'(highs), 3);

        // Counter stall at max, then re-enable
        run_to(4'd15);
        cnt_en = 1'b0;
        total_w = 0; changes = 0; pwm_last = pwm;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (wrap) total_w++;
            if (pwm !== pwm_last) changes++;
            pwm_last = pwm;
        end
        check("stall_no_wrap", 32'(total_w), 0);
        check("stall_pwm_steady", 32'(changes), 0);
        check("stall_pwm_level", 32'(pwm), 0);
        cnt_en = 1'b1;
        total_w = 0; wrap_at = -1;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (wrap) begin
                total_w++;
                wrap_at = int'(count);
            end
        end
        check("resume_one_wrap", 32'(total_w), 1);
        check("resume_wrap_at", 32'(wrap_at), 1);

        // Counter cleared from a non-max value: no wrap
        run_to(4'd7);
        cnt_en = 1'b0;
        count = '0;
        tick();
        check("nonmax_clr_cnt_q", 32'(cnt_q), 0);
        cnt_en = 1'b1;
        total_w = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wrap) total_w++;
        end
        check("nonmax_clr_no_wrap", 32'(total_w), 0);

        // Coincident load and wrap with busy low
        run_to(4'd0);
        load(4'd6);
        check("coin_wrap", 32'(wrap), 1);
        check("coin_busy_set", 32'(busy), 1);
        highs = pwm ? 1 : 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (pwm) highs++;
        end
        check("coin_old_duty", 32'(highs), 3);
        check("coin_busy_until_wrap", 32'(busy), 1);
        measure(highs, wraps, low_at, wrap_at);
        check("coin_new_duty", 32'(highs), 6);
        check("coin_busy_clear", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
